// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port (instruction fetch / data) arbiter in front of a single RAM that
// uses a MOV/MOC handshake. A three-state FSM (IDLE -> ACCESS -> RELEASE)
// serves one request at a time. The RAM address, write data and direction are
// registered on grant and held stable for the whole access.
//
// Parameters
//   DATA_PRIORITY  : 1 = data port wins a tie, 0 = round-robin on ties
//   TIMEOUT_CYCLES : ACCESS cycles without MOC before abort (1..255);
//                    only used when MEM_ARB_TIMEOUT_EN is defined
//
// Optional feature (macro MEM_ARB_TIMEOUT_EN)
//   Defined   : ACCESS is aborted after TIMEOUT_CYCLES cycles without MOC.
//               The winner's ack pulses without an rdata update, and the
//               sticky timeout_err flag is set.
//   Undefined : ACCESS waits for MOC indefinitely and timeout_err is tied 0.
//
// Ports
//   clk, reset            : rising-edge clock, asynchronous active-low reset
//   if_req/if_addr        : fetch request (held until if_ack), fetch address
//   if_ack/if_rdata       : one-cycle fetch completion, registered fetch data
//   d_req/d_rw/d_addr/
//   d_wdata               : data request (held until d_ack), 1=read 0=write,
//                           address, write data
//   d_ack/d_rdata         : one-cycle data completion, registered load data
//   mem_addr/mem_wdata    : RAM address / write data
//   mem_rdata             : RAM read data
//   MOV/RW/MOC            : operation valid, 1=read 0=write, operation complete
//   busy                  : FSM not in IDLE
//   grant                 : current/last owner, 0 = fetch, 1 = data
//   timeout_err           : sticky timeout flag
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int DATA_PRIORITY  = 1,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        MOV,
  output logic        RW,
  input  logic        MOC,
  output logic        busy,
  output logic        grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state;
  logic   last_data;  // round-robin pointer: 1 = data port was served last
  logic   win_data;

  // Data wins when it is the only requester, when data has priority on a tie,
  // or when round-robin says fetch was served last.
  always_comb begin
    // NOTE: assign a default first so every path writes the signal and no
    // latch is inferred.
    win_data = 1'b0;
    if (d_req)
      win_data = !if_req || (DATA_PRIORITY != 0) || !last_data;
  end

  assign busy = (state != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_data <= 1'b1;  // fetch wins the first tie after reset
      MOV       <= 1'b0;
      RW        <= 1'b1;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      grant     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      // Acks are single-cycle pulses.
      if_ack <= 1'b0;
      d_ack  <= 1'b0;

      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            grant     <= win_data;
            last_data <= win_data;
            MOV       <= 1'b1;
            state     <= ACCESS;
            if (win_data) begin
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              RW        <= d_rw;
            end else begin
              // Fetch is always a read; mem_wdata keeps its old value.
              mem_addr <= if_addr;
              RW       <= 1'b1;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end

        ACCESS: begin
          if (MOC) begin
            MOV   <= 1'b0;
            state <= RELEASE;
            if (grant) begin
              d_ack <= 1'b1;
              if (RW) d_rdata <= mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          // Abort on the edge where the count would reach TIMEOUT_CYCLES, so
          // MOV is high for exactly TIMEOUT_CYCLES cycles.
          else if (tmo_cnt == TMO_LAST) begin
            MOV         <= 1'b0;
            state       <= RELEASE;
            timeout_err <= 1'b1;
            if (grant) d_ack  <= 1'b1;
            else       if_ack <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end

        RELEASE: begin
          // No new access until the RAM has dropped MOC.
          if (!MOC) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifndef MEM_ARB_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. The main instance uses round-robin ties
// (DATA_PRIORITY=0); a second instance with DATA_PRIORITY=1 shares all inputs
// and is checked for data-first tie resolution. TIMEOUT_CYCLES=4 on both.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_rw, MOC;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;

  logic        if_ack, d_ack, MOV, RW, busy, grant, timeout_err;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  logic        p_if_ack, p_d_ack, p_MOV, p_RW, p_busy, p_grant, p_timeout_err;
  logic [31:0] p_if_rdata, p_d_rdata, p_mem_addr, p_mem_wdata;

  int total = 0;
  int bad   = 0;
  int if_ack_cnt = 0;
  int d_ack_cnt  = 0;
  bit both_ack   = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_PRIORITY(0), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .MOV(MOV), .RW(RW), .MOC(MOC),
    .busy(busy), .grant(grant), .timeout_err(timeout_err)
  );

  mem_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(4)) u_dp (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(p_if_ack), .if_rdata(p_if_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(p_d_ack), .d_rdata(p_d_rdata),
    .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_rdata(mem_rdata),
    .MOV(p_MOV), .RW(p_RW), .MOC(MOC),
    .busy(p_busy), .grant(p_grant), .timeout_err(p_timeout_err)
  );

  // Ack pulse monitor, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (if_ack) if_ack_cnt++;
    if (d_ack)  d_ack_cnt++;
    if (if_ack && d_ack) both_ack = 1'b1;
  end

  // Stimulus helper: waits (bounded) until MOV is seen high on a falling edge.
  task automatic wait_mov(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (MOV) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Stimulus helper: one complete access; acked reports the ack pulse.
  task automatic do_access(input bit is_data, input logic rw_in,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int wait_cyc,
                           output bit acked);
    bit ok;
    acked = 1'b0;
    if (is_data) begin
      d_req = 1'b1; d_rw = rw_in; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    wait_mov(ok);
    if (ok) begin
      repeat (wait_cyc) @(negedge clk);
      MOC = 1'b1; mem_rdata = rdata;
      @(negedge clk);
      acked = is_data ? d_ack : if_ack;
    end
    if_req = 1'b0; d_req = 1'b0; MOC = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_rw = 1'b1; MOC = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (MOV !== 1'b0) begin bad++; $display("FAIL reset_mov: got %b want 0", MOV); end
    total++; if (RW !== 1'b1) begin bad++; $display("FAIL reset_rw: got %b want 1", RW); end
    total++; if ({if_ack, d_ack, busy, grant, timeout_err} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000", {if_ack, d_ack, busy, grant, timeout_err});
    end
    total++; if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
      bad++; $display("FAIL reset_regs: got %h %h %h %h want 0", mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch_read;
    int c0;
    c0 = if_ack_cnt;
    if_addr = 32'h100; if_req = 1'b1;
    @(negedge clk);  // first ACCESS cycle
    total++; if ({MOV, RW, busy, grant} !== 4'b1110) begin
      bad++; $display("FAIL fetch_issue: got MOV/RW/busy/grant=%b want 1110", {MOV, RW, busy, grant});
    end
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL fetch_addr: got %h want 00000100", mem_addr); end
    repeat (2) @(negedge clk);
    total++; if (MOV !== 1'b1 || if_ack !== 1'b0) begin
      bad++; $display("FAIL fetch_wait: got MOV=%b ack=%b want 1 0", MOV, if_ack);
    end
    MOC = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (if_ack !== 1'b1 || MOV !== 1'b0) begin
      bad++; $display("FAIL fetch_ack: got ack=%b MOV=%b want 1 0", if_ack, MOV);
    end
    total++; if (if_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL fetch_rdata: got %h want deadbeef", if_rdata); end
    if_req = 1'b0; MOC = 1'b0; mem_rdata = '0;
    @(negedge clk);
    total++; if (if_ack !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL fetch_done: got ack=%b busy=%b want 0 0", if_ack, busy);
    end
    total++; if (if_ack_cnt - c0 !== 1) begin bad++; $display("FAIL fetch_ack_count: got %0d want 1", if_ack_cnt - c0); end
  endtask

  task automatic test_data_write;
    bit ok;
    int c0;
    do_access(1'b1, 1'b1, 32'h300, 32'h0, 32'hCAFEF00D, 0, ok);
    total++; if (!ok || d_rdata !== 32'hCAFEF00D) begin
      bad++; $display("FAIL data_read: got ack=%b rdata=%h want 1 cafef00d", ok, d_rdata);
    end
    c0 = d_ack_cnt;
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h200; d_wdata = 32'h12345678;
    @(negedge clk);
    total++; if ({MOV, RW, grant} !== 3'b101) begin
      bad++; $display("FAIL write_issue: got MOV/RW/grant=%b want 101", {MOV, RW, grant});
    end
    total++; if (mem_wdata !== 32'h12345678 || mem_addr !== 32'h200) begin
      bad++; $display("FAIL write_bus: got %h @%h want 12345678 @00000200", mem_wdata, mem_addr);
    end
    MOC = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    total++; if (d_ack !== 1'b1 || if_ack !== 1'b0) begin
      bad++; $display("FAIL write_ack: got d_ack=%b if_ack=%b want 1 0", d_ack, if_ack);
    end
    total++; if (d_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL write_keeps_rdata: got %h want cafef00d", d_rdata); end
    d_req = 1'b0; MOC = 1'b0;
    @(negedge clk);
    total++; if (d_ack_cnt - c0 !== 1) begin bad++; $display("FAIL write_ack_count: got %0d want 1", d_ack_cnt - c0); end
    // A following fetch must leave mem_wdata untouched.
    do_access(1'b0, 1'b1, 32'h104, 32'h0, 32'h11112222, 1, ok);
    total++; if (!ok || if_rdata !== 32'h11112222) begin
      bad++; $display("FAIL fetch2: got ack=%b rdata=%h want 1 11112222", ok, if_rdata);
    end
    total++; if (mem_wdata !== 32'h12345678 || RW !== 1'b1) begin
      bad++; $display("FAIL fetch_wdata_hold: got %h RW=%b want 12345678 1", mem_wdata, RW);
    end
    total++; if (d_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL fetch_keeps_drdata: got %h want cafef00d", d_rdata); end
  endtask

  task automatic test_tie;
    bit ok;
    logic [3:0] exp_grant;
    exp_grant = 4'b1010;  // bit i = owner of access i: fetch, data, fetch, data
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h1000; d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h2000;
    for (int i = 0; i < 4; i++) begin
      wait_mov(ok);
      total++; if (!ok || grant !== exp_grant[i]) begin
        bad++; $display("FAIL tie_rr_grant%0d: got mov=%b grant=%b want 1 %b", i, ok, grant, exp_grant[i]);
      end
      total++; if (p_grant !== 1'b1) begin bad++; $display("FAIL tie_prio_grant%0d: got %b want 1", i, p_grant); end
      MOC = 1'b1; mem_rdata = 32'(i + 1);
      @(negedge clk);
      total++; if ({if_ack, d_ack} !== (exp_grant[i] ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL tie_ack%0d: got if/d=%b%b want %b", i, if_ack, d_ack, exp_grant[i] ? 2'b01 : 2'b10);
      end
      MOC = 1'b0;
      if (i == 3) begin if_req = 1'b0; d_req = 1'b0; end
      @(negedge clk);
    end
    total++; if (if_rdata !== 32'd3 || d_rdata !== 32'd4) begin
      bad++; $display("FAIL tie_rdata: got %h %h want 00000003 00000004", if_rdata, d_rdata);
    end
  endtask

  task automatic test_moc_hold;
    bit ok;
    if_req = 1'b1; if_addr = 32'h400;
    wait_mov(ok);
    MOC = 1'b1; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    total++; if (!ok || if_ack !== 1'b1) begin bad++; $display("FAIL hold_first_ack: got mov=%b ack=%b want 1 1", ok, if_ack); end
    if_req = 1'b0; d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h500;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if ({MOV, busy, d_ack} !== 3'b010) begin
        bad++; $display("FAIL hold_release%0d: got MOV/busy/ack=%b want 010", i, {MOV, busy, d_ack});
      end
    end
    MOC = 1'b0;
    @(negedge clk);
    total++; if ({MOV, busy} !== 2'b00) begin bad++; $display("FAIL hold_idle: got MOV/busy=%b want 00", {MOV, busy}); end
    @(negedge clk);
    total++; if ({MOV, grant} !== 2'b11 || mem_addr !== 32'h500) begin
      bad++; $display("FAIL hold_next: got MOV/grant=%b addr=%h want 11 00000500", {MOV, grant}, mem_addr);
    end
    MOC = 1'b1; mem_rdata = 32'h0F0F0F0F;
    @(negedge clk);
    total++; if (d_ack !== 1'b1 || d_rdata !== 32'h0F0F0F0F) begin
      bad++; $display("FAIL hold_data: got ack=%b rdata=%h want 1 0f0f0f0f", d_ack, d_rdata);
    end
    d_req = 1'b0; MOC = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_req_drop;
    bit ok;
    if_req = 1'b1; if_addr = 32'h600;
    wait_mov(ok);
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (!ok || MOV !== 1'b1) begin bad++; $display("FAIL drop_mov: got %b want 1", MOV); end
    MOC = 1'b1; mem_rdata = 32'h77;
    @(negedge clk);
    total++; if (if_ack !== 1'b1 || if_rdata !== 32'h77) begin
      bad++; $display("FAIL drop_ack: got ack=%b rdata=%h want 1 00000077", if_ack, if_rdata);
    end
    MOC = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access;
    bit ok;
    int c_if, c_d;
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h700;
    wait_mov(ok);
    @(negedge clk);  // second ACCESS cycle
    total++; if (!ok || MOV !== 1'b1) begin bad++; $display("FAIL rst_mid_pre: got %b want 1", MOV); end
    c_if = if_ack_cnt; c_d = d_ack_cnt;
    reset = 1'b0;
    #1;
    total++; if ({MOV, busy, grant} !== 3'b000 || mem_addr !== 32'h0) begin
      bad++; $display("FAIL rst_mid_async: got MOV/busy/grant=%b addr=%h want 000 0", {MOV, busy, grant}, mem_addr);
    end
    d_req = 1'b0;
    MOC = 1'b1;  // a late completion must not produce an ack
    repeat (2) @(negedge clk);
    MOC = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (if_ack_cnt !== c_if || d_ack_cnt !== c_d || MOV !== 1'b0) begin
      bad++; $display("FAIL rst_mid_noack: got acks %0d/%0d MOV=%b want 0/0 0", if_ack_cnt - c_if, d_ack_cnt - c_d, MOV);
    end
    total++; if (d_rdata !== 32'h0 || if_rdata !== 32'h0) begin
      bad++; $display("FAIL rst_mid_rdata: got %h %h want 0 0", if_rdata, d_rdata);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int mov_cycles;
    if_req = 1'b1; if_addr = 32'h800; mem_rdata = 32'hAAAA5555;
    wait_mov(ok);
    mov_cycles = 0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 0; i < 20; i++) begin
      if (!MOV) break;
      mov_cycles++;
      @(negedge clk);
    end
    total++; if (!ok || mov_cycles !== 4) begin bad++; $display("FAIL tmo_mov_cycles: got %0d want 4", mov_cycles); end
    total++; if ({if_ack, timeout_err} !== 2'b11) begin
      bad++; $display("FAIL tmo_abort: got ack/err=%b want 11", {if_ack, timeout_err});
    end
    total++; if (if_rdata !== 32'h0) begin bad++; $display("FAIL tmo_rdata: got %h want 0", if_rdata); end
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({timeout_err, busy} !== 2'b10) begin
      bad++; $display("FAIL tmo_sticky: got err/busy=%b want 10", {timeout_err, busy});
    end
`else
    for (int i = 0; i < 20; i++) begin
      if (MOV) mov_cycles++;
      @(negedge clk);
    end
    total++; if (!ok || mov_cycles !== 20 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL no_tmo_wait: got %0d cycles err=%b want 20 0", mov_cycles, timeout_err);
    end
    MOC = 1'b1;
    @(negedge clk);
    total++; if (if_ack !== 1'b1 || if_rdata !== 32'hAAAA5555) begin
      bad++; $display("FAIL no_tmo_ack: got ack=%b rdata=%h want 1 aaaa5555", if_ack, if_rdata);
    end
    if_req = 1'b0; MOC = 1'b0;
    @(negedge clk);
`endif
  endtask

  task automatic test_ack_exclusive;
    total++; if (both_ack !== 1'b0) begin bad++; $display("FAIL ack_exclusive: got both acks high, want never"); end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_data_write();
    test_tie();
    test_moc_hold();
    test_req_drop();
    test_reset_mid_access();
    test_timeout();
    test_ack_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case any wait is unbounded by mistake.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1);
  end

endmodule
